// File: rtl/fir_coeff_loader.sv
// rtl/fir_coeff_loader.sv - shadow/active coefficient bank loader for the 16-tap FIR
module fir_coeff_loader #(
    parameter int NTAPS = 16,
    parameter int CW    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  load_abort,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CW-1:0]         cfg_data,
    input  logic                  cfg_last,
    input  logic                  sample_en,
    output logic [NTAPS*CW-1:0]   coeff_flat,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [3:0]            coeff_ver
);
    localparam int IW = $clog2(NTAPS);

    typedef enum logic [1:0] {IDLE, LOAD, PEND} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [CW-1:0] shadow [NTAPS];
    logic          fire;
    logic          at_end;

    assign fire   = cfg_valid & cfg_ready;
    assign at_end = (idx == IW'(NTAPS - 1));

    // coeff_flat is the active bank itself, so it can only move on a commit edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            cfg_ready  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            coeff_ver  <= '0;
            coeff_flat <= '0;
            for (int k = 0; k < NTAPS; k++) shadow[k] <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start && !load_abort) begin
                        state     <= LOAD;
                        idx       <= '0;
                        cfg_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_abort) begin
                        state     <= IDLE;
                        cfg_ready <= 1'b0;
                        busy      <= 1'b0;
                    end else if (fire) begin
                        shadow[idx] <= cfg_data;
                        idx         <= idx + 1'b1;
                        if (cfg_last && at_end) begin
                            state     <= PEND;
                            cfg_ready <= 1'b0;
                        end else if (cfg_last || at_end) begin
                            // framing error: early or missing last; active bank untouched
                            state     <= IDLE;
                            cfg_ready <= 1'b0;
                            busy      <= 1'b0;
                            err       <= 1'b1;
                        end
                    end
                end
                PEND: begin
                    if (load_abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (sample_en) begin
                        for (int k = 0; k < NTAPS; k++) coeff_flat[k*CW +: CW] <= shadow[k];
                        coeff_ver <= coeff_ver + 1'b1;
                        done      <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule
